// File: rtl/mdu.sv
// Multiply/divide unit holding the architectural HI/LO registers.
// Arithmetic results are computed at issue and committed after a fixed Busy latency.
module mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       MDUop,
  input  logic             Start,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic [WIDTH-1:0] hi_q, lo_q, pend_hi_q, pend_lo_q;

  logic [WIDTH-1:0]   res_hi_d, res_lo_d;
  logic [CW-1:0]      cnt_d;
  logic               is_arith;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, b_mag_safe, b_safe;
  logic [WIDTH-1:0]   mag_q, mag_r, uq, ur;
  logic [2*WIDTH-1:0] prod_s, prod_u;

  // Result datapath: full-width products, sign-magnitude signed divide, zero-divisor rule.
  always_comb begin
    is_arith   = (MDUop >= 3'd1) && (MDUop <= 3'd4);
    a_neg      = A[WIDTH-1];
    b_neg      = B[WIDTH-1];
    a_mag      = a_neg ? -A : A;
    b_mag      = b_neg ? -B : B;
    b_mag_safe = (b_mag == '0) ? ONE : b_mag;
    b_safe     = (B == '0) ? ONE : B;
    mag_q      = a_mag / b_mag_safe;
    mag_r      = a_mag % b_mag_safe;
    uq         = A / b_safe;
    ur         = A % b_safe;
    prod_s     = $signed({{WIDTH{a_neg}}, A}) * $signed({{WIDTH{b_neg}}, B});
    prod_u     = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    cnt_d      = (MDUop <= 3'd2) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
    res_hi_d   = '0;
    res_lo_d   = '0;
    case (MDUop)
      3'd1: {res_hi_d, res_lo_d} = prod_s;
      3'd2: {res_hi_d, res_lo_d} = prod_u;
      3'd3: begin
        if (B == '0) begin
          res_lo_d = {WIDTH{1'b1}};
          res_hi_d = A;
        end else begin
          res_lo_d = (a_neg ^ b_neg) ? -mag_q : mag_q;
          res_hi_d = a_neg ? -mag_r : mag_r;
        end
      end
      3'd4: begin
        if (B == '0) begin
          res_lo_d = {WIDTH{1'b1}};
          res_hi_d = A;
        end else begin
          res_lo_d = uq;
          res_hi_d = ur;
        end
      end
      default: begin
        res_hi_d = '0;
        res_lo_d = '0;
      end
    endcase
  end

  // Control FSM; MTHI/MTLO take priority over a simultaneous Start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (MDUop == 3'd5) begin
            hi_q <= A;
          end else if (MDUop == 3'd6) begin
            lo_q <= A;
          end else if (Start && is_arith) begin
            pend_hi_q <= res_hi_d;
            pend_lo_q <= res_lo_d;
            cnt_q     <= cnt_d;
            busy_q    <= 1'b1;
            state_q   <= RUN;
          end else begin
            busy_q <= 1'b0;
          end
        end
        RUN: begin
          if (cnt_q <= CW'(1)) begin
            hi_q    <= pend_hi_q;
            lo_q    <= pend_lo_q;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Randomized self-checking bench for mdu: a 32-bit default instance and a
// 16-bit short-latency instance checked against an arithmetic reference model.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a32, b32, hi32, lo32;
  logic [15:0] a16, b16, hi16, lo16;
  logic [2:0]  op32, op16;
  logic        st32, st16, busy32, busy16;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_hi [2];
  logic [31:0] m_lo [2];

  mdu dut32 (
    .clk(clk), .reset(reset), .A(a32), .B(b32), .MDUop(op32), .Start(st32),
    .Busy(busy32), .HI(hi32), .LO(lo32)
  );

  mdu #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
    .clk(clk), .reset(reset), .A(a16), .B(b16), .MDUop(op16), .Start(st16),
    .Busy(busy16), .HI(hi16), .LO(lo16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural result of one instruction on a w-bit machine, from plain integer arithmetic.
  function automatic void ref_op(input int w, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, inout logic [31:0] hi, inout logic [31:0] lo);
    logic [63:0] mask, ua, ub, p;
    longint sa, sb, q, r;
    mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'h0000_0000_0000_FFFF;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = ua[w-1] ? longint'(ua) - longint'(mask) - 64'sd1 : longint'(ua);
    sb = ub[w-1] ? longint'(ub) - longint'(mask) - 64'sd1 : longint'(ub);
    case (op)
      3'd1, 3'd2: begin
        p  = (op == 3'd1) ? 64'(sa * sb) : ua * ub;
        hi = 32'((p >> w) & mask);
        lo = 32'(p & mask);
      end
      3'd3: begin
        if (ub == 64'd0) begin
          lo = 32'(mask); hi = 32'(ua);
        end else begin
          q = sa / sb; r = sa % sb;
          lo = 32'(64'(q) & mask); hi = 32'(64'(r) & mask);
        end
      end
      3'd4: begin
        if (ub == 64'd0) begin
          lo = 32'(mask); hi = 32'(ua);
        end else begin
          lo = 32'(ua / ub); hi = 32'(ua % ub);
        end
      end
      3'd5: hi = 32'(ua);
      3'd6: lo = 32'(ua);
      default: ;
    endcase
  endfunction

  task automatic drive(input int sel, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic st);
    if (sel == 1) begin
      op16 = op; a16 = a[15:0]; b16 = b[15:0]; st16 = st;
    end else begin
      op32 = op; a32 = a; b32 = b; st32 = st;
    end
  endtask

  function automatic logic get_busy(input int sel);
    return (sel == 1) ? busy16 : busy32;
  endfunction
  function automatic logic [31:0] get_hi(input int sel);
    return (sel == 1) ? {16'd0, hi16} : hi32;
  endfunction
  function automatic logic [31:0] get_lo(input int sel);
    return (sel == 1) ? {16'd0, lo16} : lo32;
  endfunction

  // Issue one instruction and follow it to completion; inj adds ignored MTLO/Start mid-run.
  task automatic do_op(input int sel, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic st, input bit inj);
    int n, cnt, w;
    logic [31:0] eh, el, ph, pl;
    bit arith;
    w  = (sel == 1) ? 16 : 32;
    ph = m_hi[sel]; pl = m_lo[sel];
    eh = ph; el = pl;
    arith = st && (op >= 3'd1) && (op <= 3'd4);
    if (arith || op == 3'd5 || op == 3'd6) ref_op(w, op, a, b, eh, el);
    if (!arith) n = 0;
    else if (op <= 3'd2) n = (sel == 1) ? 1 : 5;
    else n = (sel == 1) ? 3 : 10;
    drive(sel, op, a, b, st);
    @(posedge clk); #1;
    drive(sel, 3'd0, 32'd0, 32'd0, 1'b0);
    cnt = 0;
    while (get_busy(sel) && cnt < 40) begin
      cnt++;
      chk("hold_hi", get_hi(sel), ph);
      chk("hold_lo", get_lo(sel), pl);
      if (inj && cnt == 2) drive(sel, 3'd6, 32'hDEAD_BEEF, 32'd0, 1'b0);
      else if (inj && cnt == 3) drive(sel, 3'd1, $urandom, $urandom, 1'b1);
      else drive(sel, 3'd0, 32'd0, 32'd0, 1'b0);
      @(posedge clk); #1;
    end
    drive(sel, 3'd0, 32'd0, 32'd0, 1'b0);
    chk("busy_len", 32'(cnt), 32'(n));
    chk("hi", get_hi(sel), eh);
    chk("lo", get_lo(sel), el);
    m_hi[sel] = eh;
    m_lo[sel] = el;
  endtask

  function automatic logic [31:0] pick(input int sel);
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'd0;
      1: v = 32'hFFFF_FFFF;
      2: v = (sel == 1) ? 32'h0000_8000 : 32'h8000_0000;
      3: v = 32'd1;
      default: v = $urandom;
    endcase
    return (sel == 1) ? (v & 32'h0000_FFFF) : v;
  endfunction

  initial begin
    reset = 1'b1;
    drive(0, 3'd0, 32'd0, 32'd0, 1'b0);
    drive(1, 3'd0, 32'd0, 32'd0, 1'b0);
    for (int s = 0; s < 2; s++) begin
      m_hi[s] = 32'd0; m_lo[s] = 32'd0;
    end
    #12;
    for (int s = 0; s < 2; s++) begin
      chk("rst_busy", 32'(get_busy(s)), 32'd0);
      chk("rst_hi", get_hi(s), 32'd0);
      chk("rst_lo", get_lo(s), 32'd0);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    do_op(0, 3'd1, 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0);
    chk("mult_hi_const", hi32, 32'hFFFF_FFFF);
    chk("mult_lo_const", lo32, 32'hFFFF_FFEB);
    do_op(0, 3'd2, 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0);
    do_op(0, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    chk("div_lo_const", lo32, 32'hFFFF_FFFD);
    do_op(0, 3'd4, 32'd7, 32'd2, 1'b1, 1'b0);
    do_op(0, 3'd4, 32'd5, 32'd0, 1'b1, 1'b0);
    do_op(0, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op(0, 3'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    do_op(0, 3'd6, 32'h9ABC_DEF0, 32'd0, 1'b0, 1'b0);
    do_op(0, 3'd5, 32'h0BAD_F00D, 32'd0, 1'b1, 1'b0);
    do_op(1, 3'd1, 32'h8000, 32'h8000, 1'b1, 1'b0);
    do_op(1, 3'd3, 32'h8000, 32'hFFFF, 1'b1, 1'b1);

    // Asynchronous reset three cycles into a divide; no commit may follow.
    drive(0, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    @(posedge clk); #1;
    drive(0, 3'd0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy32), 32'd0);
    chk("arst_hi", hi32, 32'd0);
    chk("arst_lo", lo32, 32'd0);
    chk("arst_hi16", {16'd0, hi16}, 32'd0);
    for (int s = 0; s < 2; s++) begin
      m_hi[s] = 32'd0; m_lo[s] = 32'd0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("late_busy", 32'(busy32), 32'd0);
    chk("late_hi", hi32, 32'd0);
    chk("late_lo", lo32, 32'd0);
    do_op(0, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);

    for (int i = 0; i < 80; i++) begin
      int sel;
      sel = int'($urandom_range(0, 1));
      do_op(sel, 3'($urandom_range(0, 7)), pick(sel), pick(sel),
            1'($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
